// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding and the
// step-overrun limit derived from the counter width.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    SHOW  = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 8;

  // Longest legal run is 2**width - 1 increments plus the match cycle,
  // so one more COUNT cycle than that means the counter never arrived.
  function automatic int step_limit(input int width);
    return (1 << width) + 1;
  endfunction

  localparam int STEP_LIMIT = step_limit(DEF_WIDTH);

endpackage

// File: rtl/ctr_seq_timer.sv
// Loadable down-counter with a zero flag; saturates at zero.
module ctr_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer for the loadable counter: load a start value, count to the stop
// value, then drive the bus for hold_len+1 cycles, optionally repeating.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic              abort,
  input  logic              repeat_en,
  input  logic [WIDTH-1:0]  start_val,
  input  logic [WIDTH-1:0]  stop_val,
  input  logic [HOLD_W-1:0] hold_len,
  input  logic [WIDTH-1:0]  cnt_in,
  output logic              load,
  output logic              cnt_en,
  output logic              oe,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int STEP_W = WIDTH + 1;
  localparam logic [STEP_W-1:0] STEP_INIT = STEP_W'(step_limit(WIDTH) - 1);

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  stop_q;
  logic [HOLD_W-1:0] hold_q;
  logic              capture, tmr_load, step_dec, hold_dec, err_set;
  logic              step_zero, hold_zero, match;

  // The counter datapath loads start_val straight off the shared bus.
  logic unused_start_val;
  assign unused_start_val = ^start_val;

  assign match = (cnt_in == stop_q);
  assign busy  = (state != IDLE);

  ctr_seq_timer #(.W(STEP_W)) u_step_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .dec      (step_dec),
    .load_val (STEP_INIT),
    .zero     (step_zero)
  );

  ctr_seq_timer #(.W(HOLD_W)) u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .dec      (hold_dec),
    .load_val (hold_q),
    .zero     (hold_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      stop_q <= '0;
      hold_q <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        stop_q <= stop_val;
        hold_q <= hold_len;
        err    <= 1'b0;
      end else if (err_set) begin
        err <= 1'b1;
      end
    end
  end

  // Both timers are armed in LOAD so every pass, including repeats, starts fresh.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    cnt_en    = 1'b0;
    oe        = 1'b0;
    done      = 1'b0;
    capture   = 1'b0;
    tmr_load  = 1'b0;
    step_dec  = 1'b0;
    hold_dec  = 1'b0;
    err_set   = 1'b0;
    if (ena) begin
      case (state)
        IDLE: begin
          if (start) begin
            capture   = 1'b1;
            state_nxt = LOAD;
          end
        end
        LOAD: begin
          load      = 1'b1;
          tmr_load  = 1'b1;
          state_nxt = abort ? IDLE : COUNT;
        end
        COUNT: begin
          cnt_en = !match;
          if (abort) begin
            state_nxt = IDLE;
          end else if (match) begin
            state_nxt = SHOW;
          end else if (step_zero) begin
            err_set   = 1'b1;
            state_nxt = IDLE;
          end else begin
            step_dec = 1'b1;
          end
        end
        SHOW: begin
          oe = 1'b1;
          if (abort) begin
            state_nxt = IDLE;
          end else if (hold_zero) begin
            done      = 1'b1;
            state_nxt = repeat_en ? LOAD : IDLE;
          end else begin
            hold_dec = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural 8-bit counter beside it.
module tb_counter_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ena, start, abort, repeat_en, stuck;
  logic [7:0] start_val, stop_val, cnt_in, ctr;
  logic [3:0] hold_len;
  logic       load, cnt_en, oe, busy, done, err;

  int total = 0;
  int bad   = 0;
  int n_load, n_cnt, n_oe, n_done, n_idle, done_at, cyc;
  int n_excl = 0;
  logic oe_at_done;

  counter_seq_ctrl #(.WIDTH(8), .HOLD_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .abort     (abort),
    .repeat_en (repeat_en),
    .start_val (start_val),
    .stop_val  (stop_val),
    .hold_len  (hold_len),
    .cnt_in    (cnt_in),
    .load      (load),
    .cnt_en    (cnt_en),
    .oe        (oe),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Counter datapath model; stuck forces its visible value to 0x00.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ctr <= 8'h00;
    else if (load)   ctr <= start_val;
    else if (cnt_en) ctr <= ctr + 8'h01;
  end
  assign cnt_in = stuck ? 8'h00 : ctr;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Presents one start request; returns at the negedge of the LOAD cycle.
  task automatic applyStimulus(input logic [7:0] sv, input logic [7:0] pv,
                               input logic [3:0] hl, input logic rep);
    start_val = sv;
    stop_val  = pv;
    hold_len  = hl;
    repeat_en = rep;
    start     = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    n_load = 0; n_cnt = 0; n_oe = 0; n_done = 0; n_idle = 0;
    done_at = -1; cyc = 0; oe_at_done = 1'b0;
  endtask

  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      n_load += int'(load);
      n_cnt  += int'(cnt_en);
      n_oe   += int'(oe);
      if (done) begin
        n_done++;
        done_at    = cyc;
        oe_at_done = oe;
      end
      if (int'(load) + int'(cnt_en) + int'(oe) > 1) n_excl++;
      if (!busy) n_idle++;
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0; repeat_en = 1'b0;
    start_val = 8'h00; stop_val = 8'h00; hold_len = 4'd0; stuck = 1'b0;
    @(negedge clk); #1;
    checkOutput("reset_outputs", {26'd0, load, cnt_en, oe, busy, done, err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic 0x10->0x14 hold 2");
    applyStimulus(8'h10, 8'h14, 4'd2, 1'b0);
    watch(9);
    checkOutput("t1_load_cycles", n_load, 1);
    checkOutput("t1_cnt_en_cycles", n_cnt, 4);
    checkOutput("t1_oe_cycles", n_oe, 3);
    checkOutput("t1_done_count", n_done, 1);
    checkOutput("t1_done_at", done_at, 8);
    checkOutput("t1_oe_with_done", oe_at_done, 1);
    checkOutput("t1_busy_window", n_idle, 0);
    #1;
    checkOutput("t1_busy_after", busy, 0);
    checkOutput("t1_cnt_final", cnt_in, 8'h14);

    $display("[TB] wrap 0xFE->0x01");
    applyStimulus(8'hFE, 8'h01, 4'd1, 1'b0);
    watch(7);
    checkOutput("t2_cnt_en_cycles", n_cnt, 3);
    checkOutput("t2_oe_cycles", n_oe, 2);
    checkOutput("t2_done_at", done_at, 6);
    #1;
    checkOutput("t2_err", err, 0);
    checkOutput("t2_cnt_final", cnt_in, 8'h01);

    $display("[TB] start equals stop, hold 0");
    applyStimulus(8'h33, 8'h33, 4'd0, 1'b0);
    watch(3);
    checkOutput("t3_cnt_en_cycles", n_cnt, 0);
    checkOutput("t3_oe_cycles", n_oe, 1);
    checkOutput("t3_done_at", done_at, 2);
    #1;
    checkOutput("t3_busy_after", busy, 0);

    $display("[TB] stuck counter overrun");
    stuck = 1'b1;
    applyStimulus(8'h02, 8'h05, 4'd0, 1'b0);
    watch(257);
    #1;
    checkOutput("t4_err_before_limit", err, 0);
    checkOutput("t4_busy_before_limit", busy, 1);
    watch(1);
    #1;
    checkOutput("t4_err_set", err, 1);
    checkOutput("t4_idle_after_err", busy, 0);
    checkOutput("t4_cnt_en_cycles", n_cnt, 257);
    checkOutput("t4_no_done", n_done, 0);
    stuck = 1'b0;
    applyStimulus(8'h40, 8'h41, 4'd0, 1'b0);
    #1;
    checkOutput("t4_err_cleared", err, 0);
    watch(4);
    checkOutput("t4_rerun_done", n_done, 1);

    $display("[TB] abort in COUNT");
    applyStimulus(8'h00, 8'h20, 4'd1, 1'b0);
    watch(3);
    abort = 1'b1;
    #1;
    checkOutput("t5_cnt_en_pre_abort", cnt_en, 1);
    @(negedge clk);
    abort = 1'b0;
    #1;
    checkOutput("t5_count_abort_idle", {busy, cnt_en, done}, 3'b000);
    checkOutput("t5_err_kept", err, 0);

    $display("[TB] abort in SHOW");
    applyStimulus(8'h50, 8'h51, 4'd3, 1'b0);
    watch(3);
    abort = 1'b1;
    #1;
    checkOutput("t5_show_oe_pre_abort", {oe, done}, 2'b10);
    @(negedge clk);
    abort = 1'b0;
    #1;
    checkOutput("t5_show_abort_idle", {busy, oe, done}, 3'b000);

    $display("[TB] freeze mid-COUNT, abort held in IDLE");
    abort = 1'b1;
    applyStimulus(8'h10, 8'h18, 4'd1, 1'b0);
    abort = 1'b0;
    #1;
    checkOutput("t5_idle_abort_ignored", load, 1);
    watch(4);
    ena = 1'b0;
    #1;
    checkOutput("t5_freeze_ctrls", {load, cnt_en, oe, done}, 4'b0000);
    checkOutput("t5_freeze_busy", busy, 1);
    checkOutput("t5_freeze_cnt", cnt_in, 8'h13);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("t5_frozen_cnt", cnt_in, 8'h13);
    ena = 1'b1;
    watch(8);
    checkOutput("t5_resume_cnt_en", n_cnt, 8);
    checkOutput("t5_resume_oe", n_oe, 2);
    checkOutput("t5_resume_done_at", done_at, 11);
    #1;
    checkOutput("t5_resume_final", {busy, cnt_in}, {1'b0, 8'h18});

    $display("[TB] repeat then reset mid-SHOW");
    applyStimulus(8'h20, 8'h22, 4'd1, 1'b1);
    watch(12);
    checkOutput("t6_load_cycles", n_load, 2);
    checkOutput("t6_done_count", n_done, 2);
    checkOutput("t6_done_at", done_at, 11);
    checkOutput("t6_no_idle", n_idle, 0);
    #1;
    checkOutput("t6_third_load", load, 1);
    watch(4);
    #1;
    checkOutput("t6_in_show", oe, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_reset", {load, cnt_en, oe, busy, done, err}, 6'b000000);
    repeat_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("t6_idle_after_reset", busy, 0);

    checkOutput("mutex_load_cnt_oe", n_excl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
